// File: rtl/calc_pkg.sv
// calc_pkg: shared status/state encodings and default command codes
// for the calc command scheduler.
package calc_pkg;

   typedef enum logic [1:0] {
      ST_READY = 2'b00,
      ST_BUSY  = 2'b01,
      ST_ERROR = 2'b10
   } status_e;

   localparam logic [3:0] NOP_CMD_DEF = 4'hF;
   localparam logic [3:0] CLR_CMD_DEF = 4'hE;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_ERR
   } sched_state_e;

endpackage

// File: rtl/calc_cmd_sched_if.sv
// calc_cmd_sched_if: two-requester valid/ready command bundle.
// master = command source side, slave = scheduler side.
interface calc_cmd_sched_if;
   logic [1:0]      req_valid;
   logic [1:0][3:0] req_cmd;
   logic [1:0]      req_ready;

   modport master (
      output req_valid,
      output req_cmd,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_cmd,
      output req_ready
   );
endinterface

// File: rtl/calc_cmd_fifo.sv
// calc_cmd_fifo: DEPTH x 4-bit synchronous FIFO with flush.
// Flush wins over push/pop in the same cycle.
module calc_cmd_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_push,
   input  logic                    i_pop,
   input  logic                    i_flush,
   input  logic [3:0]              i_data,
   output logic [3:0]              o_data,
   output logic [$clog2(DEPTH):0]  o_count,
   output logic                    o_full,
   output logic                    o_empty
);
   localparam int AW = $clog2(DEPTH);

   logic [3:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [AW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_count = r_count;
   assign o_data  = r_mem[r_rd];

   // a pop frees a slot, so push into a full FIFO is fine alongside it
   assign w_pop  = i_pop && !o_empty;
   assign w_push = i_push && (!o_full || w_pop);

   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + AW'(1);
         if (w_pop)  r_rd <= r_rd + AW'(1);
         r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push && !i_flush && !i_rst) r_mem[r_wr] <= i_data;
   end

endmodule

// File: rtl/calc_cmd_sched.sv
// calc_cmd_sched: arbitrates two command sources into a FIFO and issues to calc.
// Define CALC_SCHED_PRIO_EN for fixed priority (requester 0 always wins).
module calc_cmd_sched
   import calc_pkg::*;
#(
   parameter int         DEPTH   = 4,
   parameter int         TIMEOUT = 64,
   parameter logic [3:0] NOP_CMD = NOP_CMD_DEF,
   parameter logic [3:0] CLR_CMD = CLR_CMD_DEF
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   calc_cmd_sched_if.slave        req_if,
   input  logic [1:0]             i_status,
   output logic [3:0]             o_cmd_out,
   output logic [$clog2(DEPTH):0] o_fifo_count,
   output logic                   o_sched_busy,
   output logic                   o_err_flag,
   output logic [7:0]             o_drop_cnt
);
   localparam int TW = $clog2(TIMEOUT) + 1;

   sched_state_e  r_state;
   sched_state_e  w_next;
   logic [TW-1:0] r_timer;
   logic [3:0]    r_cmd_out;
   logic          r_err;
   logic [7:0]    r_drop;

   logic [1:0] w_gnt;
   logic [1:0] w_rdy;
   logic       w_full;
   logic       w_empty;
   logic       w_acc;
   logic       w_sel;
   logic       w_in_err;
   logic [3:0] w_acc_cmd;
   logic [3:0] w_head;
   logic [3:0] w_issue_cmd;
   logic       w_push;
   logic       w_pop;
   logic       w_flush;
   logic       w_err_drop;
   logic       w_err_clr;
   logic       w_err_set;
   logic       w_err_unset;
   logic       w_st_err;
   logic [8:0] w_add;
   logic [8:0] w_drop_sum;

`ifdef CALC_SCHED_PRIO_EN
   always_comb begin
      w_gnt = 2'b00;
      if (req_if.req_valid[0])      w_gnt = 2'b01;
      else if (req_if.req_valid[1]) w_gnt = 2'b10;
   end
`else
   logic r_rr;

   always_comb begin
      w_gnt = 2'b00;
      if (!r_rr)
         w_gnt = req_if.req_valid[0] ? 2'b01 : {req_if.req_valid[1], 1'b0};
      else
         w_gnt = req_if.req_valid[1] ? 2'b10 : {1'b0, req_if.req_valid[0]};
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)      r_rr <= 1'b0;
      else if (w_acc) r_rr <= ~w_sel;
   end
`endif

   assign w_in_err = (r_state == S_ERR);
   assign w_st_err = i_status[1];
   // ERR mode keeps accepting so clear/drop traffic never stalls
   assign w_rdy    = (!i_rst && (w_in_err || !w_full)) ? w_gnt : 2'b00;
   assign req_if.req_ready = w_rdy;

   assign w_acc      = |w_rdy;
   assign w_sel      = w_rdy[1];
   assign w_acc_cmd  = req_if.req_cmd[w_sel];
   assign w_push     = w_acc && !w_in_err && (w_acc_cmd != NOP_CMD);
   assign w_err_drop = w_acc && w_in_err && (w_acc_cmd != NOP_CMD)
                       && (w_acc_cmd != CLR_CMD);
   assign w_err_clr  = w_acc && w_in_err && (w_acc_cmd == CLR_CMD);

   always_comb begin
      w_next    = r_state;
      w_pop     = 1'b0;
      w_flush   = 1'b0;
      w_err_set = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               if (i_status == ST_READY) begin
                  w_pop  = 1'b1;
                  w_next = S_ISSUE;
               end else if (w_st_err) begin
                  w_flush   = 1'b1;
                  w_err_set = 1'b1;
                  w_next    = S_ERR;
               end
            end else if (w_st_err) begin
               w_err_set = 1'b1;
            end
         end
         S_ISSUE: w_next = S_WAIT;
         S_WAIT: begin
            // timer starts at 1 in WAIT, so >=2 means two WAIT cycles done
            if (r_timer >= TW'(2)) begin
               if (i_status == ST_READY) begin
                  w_next = S_IDLE;
               end else if (w_st_err || r_timer == TW'(TIMEOUT - 1)) begin
                  w_flush   = 1'b1;
                  w_err_set = 1'b1;
                  w_next    = S_ERR;
               end
            end
         end
         S_ERR: begin
            if (w_err_clr) w_next = S_ISSUE;
         end
      endcase
   end

   assign w_issue_cmd = w_in_err ? CLR_CMD : w_head;
   assign w_err_unset = (w_next == S_ISSUE) && (w_issue_cmd == CLR_CMD);
   assign w_add       = w_flush ? (9'(o_fifo_count) + 9'(w_push))
                                : 9'(w_err_drop);
   assign w_drop_sum  = {1'b0, r_drop} + w_add;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_timer   <= '0;
         r_cmd_out <= NOP_CMD;
         r_err     <= 1'b0;
         r_drop    <= 8'd0;
      end else begin
         r_state   <= w_next;
         r_cmd_out <= (w_next == S_ISSUE) ? w_issue_cmd : NOP_CMD;
         if (w_next == S_ISSUE)  r_timer <= '0;
         else if (o_sched_busy) r_timer <= r_timer + TW'(1);
         if (w_err_set)        r_err <= 1'b1;
         else if (w_err_unset) r_err <= 1'b0;
         if (w_flush || w_err_drop)
            r_drop <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
      end
   end

   calc_cmd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .i_data  (w_acc_cmd),
      .o_data  (w_head),
      .o_count (o_fifo_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign o_cmd_out    = r_cmd_out;
   assign o_sched_busy = (r_state == S_ISSUE) || (r_state == S_WAIT);
   assign o_err_flag   = r_err;
   assign o_drop_cnt   = r_drop;

endmodule

// File: tb/tb_calc_cmd_sched.sv
// tb_calc_cmd_sched: directed scenarios for the calc command scheduler.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_calc_cmd_sched;
   import calc_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] status;
   logic [3:0] cmd_out;
   logic [2:0] fifo_count;
   logic       busy;
   logic       err;
   logic [7:0] drop;
   int         errors = 0;
   int         checks = 0;

   calc_cmd_sched_if u_if ();

   calc_cmd_sched #(
      .DEPTH   (4),
      .TIMEOUT (64)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .req_if       (u_if),
      .i_status     (status),
      .o_cmd_out    (cmd_out),
      .o_fifo_count (fifo_count),
      .o_sched_busy (busy),
      .o_err_flag   (err),
      .o_drop_cnt   (drop)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      rst = 1'b1;
      u_if.req_valid = 2'b00;
      u_if.req_cmd = '0;
      status = 2'b00;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      status = 2'b10;
      u_if.req_valid = 2'b11;
      u_if.req_cmd[0] = 4'h1;
      u_if.req_cmd[1] = 4'h2;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (u_if.req_ready !== 2'b00) begin errors++;
         $display("FAIL rst_ready: got %b want 00", u_if.req_ready); end
      checks++;
      if (cmd_out !== 4'hF) begin errors++;
         $display("FAIL rst_cmd: got %h want f", cmd_out); end
      checks++;
      if (fifo_count !== 3'd0) begin errors++;
         $display("FAIL rst_count: got %0d want 0", fifo_count); end
      checks++;
      if (busy !== 1'b0) begin errors++;
         $display("FAIL rst_busy: got %b want 0", busy); end
      checks++;
      if (err !== 1'b0) begin errors++;
         $display("FAIL rst_err: got %b want 0", err); end
      checks++;
      if (drop !== 8'd0) begin errors++;
         $display("FAIL rst_drop: got %0d want 0", drop); end
      do_reset();
   endtask

   task automatic test_single();
      do_reset();
      u_if.req_valid = 2'b01;
      u_if.req_cmd[0] = 4'h3;
      #1;
      checks++;
      if (u_if.req_ready !== 2'b01) begin errors++;
         $display("FAIL single_ready: got %b want 01", u_if.req_ready); end
      @(negedge clk);
      u_if.req_valid = 2'b00;
      checks++;
      if (fifo_count !== 3'd1) begin errors++;
         $display("FAIL single_count1: got %0d want 1", fifo_count); end
      checks++;
      if (cmd_out !== 4'hF) begin errors++;
         $display("FAIL single_early: got %h want f", cmd_out); end
      @(negedge clk);
      checks++;
      if (cmd_out !== 4'h3) begin errors++;
         $display("FAIL single_issue: got %h want 3", cmd_out); end
      checks++;
      if (busy !== 1'b1 || fifo_count !== 3'd0) begin errors++;
         $display("FAIL single_issue_st: got busy=%b cnt=%0d want 1/0",
                  busy, fifo_count); end
      status = 2'b01;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (cmd_out !== 4'hF || busy !== 1'b1) begin errors++;
            $display("FAIL single_wait%0d: got cmd=%h busy=%b want f/1",
                     k, cmd_out, busy); end
      end
      status = 2'b00;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || fifo_count !== 3'd0 || cmd_out !== 4'hF) begin
         errors++;
         $display("FAIL single_done: got busy=%b cnt=%0d cmd=%h want 0/0/f",
                  busy, fifo_count, cmd_out); end
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_rdy [5];
      logic [3:0] exp_cmd [4];
      logic [2:0] exp_cnt;
      int n;
      exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
      exp_cmd = '{4'h1, 4'h2, 4'h1, 4'h2};
      do_reset();
      status = 2'b01;
      u_if.req_valid = 2'b11;
      u_if.req_cmd[0] = 4'h1;
      u_if.req_cmd[1] = 4'h2;
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++;
         if (u_if.req_ready !== exp_rdy[k]) begin errors++;
            $display("FAIL rr_ready%0d: got %b want %b",
                     k, u_if.req_ready, exp_rdy[k]); end
         @(negedge clk);
         exp_cnt = (k < 3) ? 3'(k + 1) : 3'd4;
         checks++;
         if (fifo_count !== exp_cnt) begin errors++;
            $display("FAIL rr_count%0d: got %0d want %0d",
                     k, fifo_count, exp_cnt); end
      end
      u_if.req_valid = 2'b00;
      status = 2'b00;
      for (int j = 0; j < 4; j++) begin
         n = 0;
         while (cmd_out === 4'hF && n < 10) begin
            @(negedge clk);
            n++;
         end
         checks++;
         if (cmd_out !== exp_cmd[j]) begin errors++;
            $display("FAIL rr_order%0d: got %h want %h",
                     j, cmd_out, exp_cmd[j]); end
         @(negedge clk);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (fifo_count !== 3'd0 || busy !== 1'b0) begin errors++;
         $display("FAIL rr_drain: got cnt=%0d busy=%b want 0/0",
                  fifo_count, busy); end
   endtask

   task automatic test_error_flush();
      do_reset();
      u_if.req_valid = 2'b01;
      u_if.req_cmd[0] = 4'h7;
      @(negedge clk);
      u_if.req_valid = 2'b00;
      @(negedge clk);
      checks++;
      if (cmd_out !== 4'h7) begin errors++;
         $display("FAIL flush_issue: got %h want 7", cmd_out); end
      status = 2'b01;
      u_if.req_valid = 2'b01;
      u_if.req_cmd[0] = 4'h8;
      @(negedge clk);
      u_if.req_cmd[0] = 4'h9;
      @(negedge clk);
      u_if.req_cmd[0] = 4'hA;
      @(negedge clk);
      u_if.req_valid = 2'b00;
      checks++;
      if (fifo_count !== 3'd3 || busy !== 1'b1) begin errors++;
         $display("FAIL flush_fill: got cnt=%0d busy=%b want 3/1",
                  fifo_count, busy); end
      status = 2'b10;
      @(negedge clk);
      checks++;
      if (err !== 1'b1 || busy !== 1'b0) begin errors++;
         $display("FAIL flush_err: got err=%b busy=%b want 1/0", err, busy); end
      checks++;
      if (fifo_count !== 3'd0 || drop !== 8'd3) begin errors++;
         $display("FAIL flush_drop: got cnt=%0d drop=%0d want 0/3",
                  fifo_count, drop); end
      status = 2'b00;
      u_if.req_valid = 2'b10;
      u_if.req_cmd[1] = 4'h5;
      #1;
      checks++;
      if (u_if.req_ready !== 2'b10) begin errors++;
         $display("FAIL errmode_ready: got %b want 10", u_if.req_ready); end
      @(negedge clk);
      u_if.req_valid = 2'b00;
      checks++;
      if (drop !== 8'd4 || fifo_count !== 3'd0 || err !== 1'b1) begin
         errors++;
         $display("FAIL errmode_drop: got drop=%0d cnt=%0d err=%b want 4/0/1",
                  drop, fifo_count, err); end
   endtask

   task automatic test_clear();
      u_if.req_valid = 2'b10;
      u_if.req_cmd[1] = 4'hE;
      #1;
      checks++;
      if (u_if.req_ready !== 2'b10) begin errors++;
         $display("FAIL clr_ready: got %b want 10", u_if.req_ready); end
      @(negedge clk);
      u_if.req_valid = 2'b00;
      checks++;
      if (cmd_out !== 4'hE || err !== 1'b0 || busy !== 1'b1) begin errors++;
         $display("FAIL clr_issue: got cmd=%h err=%b busy=%b want e/0/1",
                  cmd_out, err, busy); end
      @(negedge clk);
      checks++;
      if (cmd_out !== 4'hF || busy !== 1'b1) begin errors++;
         $display("FAIL clr_once: got cmd=%h busy=%b want f/1",
                  cmd_out, busy); end
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin errors++;
         $display("FAIL clr_minwait: got busy=%b want 1", busy); end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || err !== 1'b0 || drop !== 8'd4) begin errors++;
         $display("FAIL clr_idle: got busy=%b err=%b drop=%0d want 0/0/4",
                  busy, err, drop); end
   endtask

   task automatic test_timeout();
      do_reset();
      u_if.req_valid = 2'b01;
      u_if.req_cmd[0] = 4'h6;
      @(negedge clk);
      u_if.req_valid = 2'b00;
      @(negedge clk);
      checks++;
      if (cmd_out !== 4'h6) begin errors++;
         $display("FAIL to_issue: got %h want 6", cmd_out); end
      status = 2'b01;
      repeat (63) @(negedge clk);
      checks++;
      if (err !== 1'b0 || busy !== 1'b1) begin errors++;
         $display("FAIL to_early: got err=%b busy=%b want 0/1", err, busy); end
      @(negedge clk);
      checks++;
      if (err !== 1'b1 || busy !== 1'b0) begin errors++;
         $display("FAIL to_fire: got err=%b busy=%b want 1/0", err, busy); end
      checks++;
      if (drop !== 8'd0 || fifo_count !== 3'd0) begin errors++;
         $display("FAIL to_drop: got drop=%0d cnt=%0d want 0/0",
                  drop, fifo_count); end
   endtask

   task automatic test_nop_idle_err();
      do_reset();
      status = 2'b01;
      u_if.req_valid = 2'b01;
      u_if.req_cmd[0] = 4'hF;
      #1;
      checks++;
      if (u_if.req_ready !== 2'b01) begin errors++;
         $display("FAIL nop_ready: got %b want 01", u_if.req_ready); end
      @(negedge clk);
      u_if.req_valid = 2'b00;
      checks++;
      if (fifo_count !== 3'd0 || drop !== 8'd0) begin errors++;
         $display("FAIL nop_discard: got cnt=%0d drop=%0d want 0/0",
                  fifo_count, drop); end
      status = 2'b11;
      @(negedge clk);
      checks++;
      if (err !== 1'b1 || busy !== 1'b0) begin errors++;
         $display("FAIL idle_err: got err=%b busy=%b want 1/0", err, busy); end
      status = 2'b00;
      @(negedge clk);
      checks++;
      if (err !== 1'b1) begin errors++;
         $display("FAIL idle_sticky: got %b want 1", err); end
      u_if.req_valid = 2'b01;
      u_if.req_cmd[0] = 4'hE;
      @(negedge clk);
      u_if.req_valid = 2'b00;
      @(negedge clk);
      checks++;
      if (cmd_out !== 4'hE || err !== 1'b0) begin errors++;
         $display("FAIL idle_clr: got cmd=%h err=%b want e/0", cmd_out, err); end
   endtask

   task automatic test_reset_mid_wait();
      int seen;
      do_reset();
      u_if.req_valid = 2'b01;
      u_if.req_cmd[0] = 4'h3;
      @(negedge clk);
      u_if.req_valid = 2'b00;
      @(negedge clk);
      status = 2'b01;
      u_if.req_valid = 2'b01;
      u_if.req_cmd[0] = 4'h4;
      @(negedge clk);
      u_if.req_cmd[0] = 4'h5;
      @(negedge clk);
      u_if.req_valid = 2'b00;
      checks++;
      if (fifo_count !== 3'd2 || busy !== 1'b1) begin errors++;
         $display("FAIL mid_setup: got cnt=%0d busy=%b want 2/1",
                  fifo_count, busy); end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (cmd_out !== 4'hF || fifo_count !== 3'd0) begin errors++;
         $display("FAIL mid_rst: got cmd=%h cnt=%0d want f/0",
                  cmd_out, fifo_count); end
      checks++;
      if (drop !== 8'd0 || busy !== 1'b0 || err !== 1'b0) begin errors++;
         $display("FAIL mid_rst_st: got drop=%0d busy=%b err=%b want 0/0/0",
                  drop, busy, err); end
      rst = 1'b0;
      status = 2'b00;
      seen = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (cmd_out !== 4'hF) seen++;
      end
      checks++;
      if (seen !== 0) begin errors++;
         $display("FAIL mid_replay: got %0d issue cycles want 0", seen); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_error_flush();
      test_clear();
      test_timeout();
      test_nop_idle_err();
      test_reset_mid_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1);
   end

endmodule
